router_vc_xy: RTL and testbench

- Next-generation 5-port mesh router: parametrised flit width, per-input buffer depth and mesh coordinates.
- Adds two virtual channels (VC0/VC1) per input with polarity-scheduled output service, dimension-order (XY) routing on flit address fields, and round-robin output arbitration.
- Single-flit packets. Instantiated once per mesh node; the PE/NIC attaches to port 0.

---
 rtl/router_vc_xy.sv | 162 ++++++++++++++++
 tb/tb_router_vc_xy.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_vc_xy.sv
// 5-port mesh router with two virtual channels per input, XY dimension-order
// routing, polarity-scheduled VC service and per-output round-robin arbitration.
// Port order: 0=PE, 1=W, 2=E, 3=S, 4=N. Single-flit packets.
// The output flit bus is named dout because "do" is a reserved word.
module router_vc_xy #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_DEPTH = 2,
    parameter int COORD_W      = 4,
    parameter int ADDR_LSB     = 16,
    parameter int CUR_X        = 0,
    parameter int CUR_Y        = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    polarity,
    input  logic [4:0]              si,
    input  logic [5*DATA_WIDTH-1:0] di,
    output logic [9:0]              ri,
    output logic [4:0]              so,
    output logic [5*DATA_WIDTH-1:0] dout,
    input  logic [9:0]              ro
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(BUFFER_DEPTH);
    localparam logic [COORD_W-1:0] CX       = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY       = COORD_W'(CUR_Y);

    localparam logic [2:0] PORT_PE = 3'd0;
    localparam logic [2:0] PORT_W  = 3'd1;
    localparam logic [2:0] PORT_E  = 3'd2;
    localparam logic [2:0] PORT_S  = 3'd3;
    localparam logic [2:0] PORT_N  = 3'd4;

    logic [DATA_WIDTH-1:0] mem    [5][2][BUFFER_DEPTH];
    logic [PTR_W-1:0]      rd_ptr [5][2];
    logic [PTR_W-1:0]      wr_ptr [5][2];
    logic [CNT_W-1:0]      count  [5][2];
    logic [2:0]            rr_ptr [5];

    logic [DATA_WIDTH-1:0] head       [5];
    logic [2:0]            head_route [5];
    logic [4:0]            head_valid;
    logic [4:0]            ro_pol;
    logic [4:0]            grant_valid;
    logic [2:0]            grant_idx  [5];
    logic [4:0]            pop_sel;

    // XY routing: resolve X first, then Y, otherwise deliver locally
    function automatic logic [2:0] route_of(input logic [DATA_WIDTH-1:0] flit);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = flit[ADDR_LSB +: COORD_W];
        dy = flit[ADDR_LSB+COORD_W +: COORD_W];
        if (dx > CX)      return PORT_E;
        else if (dx < CX) return PORT_W;
        else if (dy > CY) return PORT_N;
        else if (dy < CY) return PORT_S;
        else              return PORT_PE;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready per input/VC: space left in that FIFO, held low during reset
    always_comb begin
        ri = '0;
        for (int i = 0; i < 5; i++) begin
            for (int v = 0; v < 2; v++) begin
                ri[2*i+v] = !reset && (count[i][v] < CNT_FULL);
            end
        end
    end

    // Head flit of the VC selected by the current polarity, with its route
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            head[i]       = mem[i][polarity][rd_ptr[i][polarity]];
            head_valid[i] = (count[i][polarity] != '0);
            head_route[i] = route_of(head[i]);
        end
    end

    // Per-output round-robin search starting at that output's pointer
    always_comb begin
        logic [3:0] sum;
        logic [2:0] cand;
        sum         = '0;
        cand        = '0;
        grant_valid = '0;
        pop_sel     = '0;
        for (int o = 0; o < 5; o++) begin
            grant_idx[o] = '0;
            ro_pol[o]    = polarity ? ro[2*o+1] : ro[2*o];
            for (int k = 0; k < 5; k++) begin
                sum  = {1'b0, rr_ptr[o]} + 4'(k);
                cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
                if (!grant_valid[o] && head_valid[cand] &&
                    head_route[cand] == 3'(o) && ro_pol[o]) begin
                    grant_valid[o] = 1'b1;
                    grant_idx[o]   = cand;
                end
            end
            if (grant_valid[o]) begin
                pop_sel[grant_idx[o]] = 1'b1;
            end
        end
    end

    // State update: polarity, output registers, RR pointers and FIFOs
    always_ff @(posedge clk) begin
        if (reset) begin
            polarity <= 1'b0;
            so       <= '0;
            dout     <= '0;
            for (int o = 0; o < 5; o++) begin
                rr_ptr[o] <= '0;
            end
            for (int i = 0; i < 5; i++) begin
                for (int v = 0; v < 2; v++) begin
                    rd_ptr[i][v] <= '0;
                    wr_ptr[i][v] <= '0;
                    count[i][v]  <= '0;
                end
            end
        end else begin
            polarity <= ~polarity;
            for (int o = 0; o < 5; o++) begin
                so[o] <= grant_valid[o];
                if (grant_valid[o]) begin
                    dout[o*DATA_WIDTH +: DATA_WIDTH] <= head[grant_idx[o]];
                    rr_ptr[o] <= (grant_idx[o] == 3'd4) ? 3'd0 : grant_idx[o] + 3'd1;
                end
            end
            for (int i = 0; i < 5; i++) begin
                for (int v = 0; v < 2; v++) begin
                    logic push;
                    logic pop;
                    push = si[i] && (di[i*DATA_WIDTH+DATA_WIDTH-1] == 1'(v)) &&
                           (count[i][v] < CNT_FULL);
                    pop  = pop_sel[i] && (polarity == 1'(v));
                    if (push) begin
                        mem[i][v][wr_ptr[i][v]] <= di[i*DATA_WIDTH +: DATA_WIDTH];
                        wr_ptr[i][v] <= ptr_inc(wr_ptr[i][v]);
                    end
                    if (pop) begin
                        rd_ptr[i][v] <= ptr_inc(rd_ptr[i][v]);
                    end
                    if (push && !pop) begin
                        count[i][v] <= count[i][v] + CNT_W'(1);
                    end else if (pop && !push) begin
                        count[i][v] <= count[i][v] - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_router_vc_xy.sv
// Self-checking bench for router_vc_xy: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_router_vc_xy;

    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int BW    = 5*DW;
    localparam logic [9:0] RO_ALL = 10'h3FF;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic [4:0]    si;
    logic [BW-1:0] di;
    logic [9:0]    ri;
    logic [4:0]    so;
    logic [BW-1:0] dout;
    logic [9:0]    ro;

    int total = 0;
    int bad   = 0;

    // Reference model state: one FIFO queue per input per VC
    logic [DW-1:0] mq [5][2][$];
    int            mptr [5];
    logic          mpol;
    logic          mrst;
    logic [4:0]    mso;
    logic [BW-1:0] mdo;

    logic [BW-1:0] dv;
    logic [4:0]    sv;
    logic [9:0]    rv;
    logic          rst;

    router_vc_xy #(
        .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .COORD_W(4), .ADDR_LSB(16),
        .CUR_X(1), .CUR_Y(1)
    ) dut (
        .clk(clk), .reset(reset), .polarity(polarity), .si(si), .di(di),
        .ri(ri), .so(so), .dout(dout), .ro(ro)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Destination port from XY rule for a node at (1,1)
    function automatic int routeOf(input logic [DW-1:0] f);
        int dx;
        int dy;
        dx = int'(f[19:16]);
        dy = int'(f[23:20]);
        if (dx > 1) return 2;
        if (dx < 1) return 1;
        if (dy > 1) return 4;
        if (dy < 1) return 3;
        return 0;
    endfunction

    function automatic logic [DW-1:0] mk(input logic vc, input logic [3:0] dx, input logic [3:0] dy);
        logic [DW-1:0] f;
        f        = {$urandom, $urandom};
        f[DW-1]  = vc;
        f[19:16] = dx;
        f[23:20] = dy;
        return f;
    endfunction

    // One clock of the reference model, using state from before the edge
    task automatic modelStep(input logic r, input logic [4:0] s, input logic [BW-1:0] d, input logic [9:0] rr);
        int sz [5][2];
        logic [4:0] popi;
        int i;
        int v;
        if (r) begin
            for (int a = 0; a < 5; a++) begin
                mq[a][0].delete();
                mq[a][1].delete();
                mptr[a] = 0;
            end
            mpol = 1'b0;
            mso  = '0;
            mdo  = '0;
            mrst = 1'b1;
            return;
        end
        mrst = 1'b0;
        popi = '0;
        for (int a = 0; a < 5; a++) begin
            sz[a][0] = mq[a][0].size();
            sz[a][1] = mq[a][1].size();
        end
        for (int o = 0; o < 5; o++) begin
            mso[o] = 1'b0;
            for (int k = 0; k < 5; k++) begin
                i = (mptr[o] + k) % 5;
                if (sz[i][mpol] > 0 && routeOf(mq[i][mpol][0]) == o && rr[2*o+int'(mpol)]) begin
                    mso[o] = 1'b1;
                    mdo[o*DW +: DW] = mq[i][mpol][0];
                    popi[i] = 1'b1;
                    mptr[o] = (i + 1) % 5;
                    break;
                end
            end
        end
        for (int a = 0; a < 5; a++) begin
            if (popi[a]) void'(mq[a][mpol].pop_front());
        end
        for (int a = 0; a < 5; a++) begin
            v = int'(d[a*DW+DW-1]);
            if (s[a] && sz[a][v] < DEPTH) mq[a][v].push_back(d[a*DW +: DW]);
        end
        mpol = ~mpol;
    endtask

    // Drive one cycle of inputs, advance the model and compare after the edge
    task automatic applyStimulus(input logic r, input logic [4:0] s, input logic [BW-1:0] d, input logic [9:0] rr);
        logic [9:0] eri;
        @(negedge clk);
        reset = r;
        si    = s;
        di    = d;
        ro    = rr;
        modelStep(r, s, d, rr);
        @(posedge clk);
        #1;
        eri = '0;
        for (int a = 0; a < 5; a++) begin
            for (int b = 0; b < 2; b++) begin
                eri[2*a+b] = !mrst && (mq[a][b].size() < DEPTH);
            end
        end
        checkOutput("polarity", BW'(polarity), BW'(mpol));
        checkOutput("so", BW'(so), BW'(mso));
        checkOutput("dout", dout, mdo);
        checkOutput("ri", BW'(ri), BW'(eri));
    endtask

    task automatic idle(input int n, input logic [9:0] rr);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, '0, '0, rr);
    endtask

    initial begin
        reset = 1'b1;
        si    = '0;
        di    = '0;
        ro    = RO_ALL;
        mpol  = 1'b0;
        mrst  = 1'b1;
        mso   = '0;
        mdo   = '0;

        // Reset then a single PE flit heading east
        applyStimulus(1'b1, '0, '0, RO_ALL);
        applyStimulus(1'b1, '0, '0, RO_ALL);
        idle(1, RO_ALL);
        dv = '0;
        dv[0 +: DW] = mk(1'b0, 4'd3, 4'd1);
        applyStimulus(1'b0, 5'b00001, dv, RO_ALL);
        idle(4, RO_ALL);

        // Routing sweep from the PE port, alternating VCs
        for (int k = 0; k < 5; k++) begin
            logic [3:0] tx [5];
            logic [3:0] ty [5];
            tx = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
            ty = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd0};
            dv = '0;
            dv[0 +: DW] = mk(1'(k % 2), tx[k], ty[k]);
            applyStimulus(1'b0, 5'b00001, dv, RO_ALL);
        end
        idle(5, RO_ALL);

        // Contention: PE, W, S and N all target E on VC0
        dv = '0;
        for (int i = 0; i < 5; i++) dv[i*DW +: DW] = mk(1'b0, 4'd2, 4'd1);
        applyStimulus(1'b0, 5'b11011, dv, RO_ALL);
        idle(10, RO_ALL);

        // Backpressure on E VC0 with three flits from W
        for (int k = 0; k < 3; k++) begin
            dv = '0;
            dv[1*DW +: DW] = mk(1'b0, 4'd3, 4'd1);
            applyStimulus(1'b0, 5'b00010, dv, RO_ALL & ~10'h010);
        end
        idle(3, RO_ALL & ~10'h010);
        idle(8, RO_ALL);

        // VC isolation: W VC0 blocked toward E, W VC1 toward N still flows
        dv = '0;
        dv[1*DW +: DW] = mk(1'b0, 4'd2, 4'd1);
        applyStimulus(1'b0, 5'b00010, dv, RO_ALL & ~10'h010);
        dv = '0;
        dv[1*DW +: DW] = mk(1'b1, 4'd1, 4'd3);
        applyStimulus(1'b0, 5'b00010, dv, RO_ALL & ~10'h010);
        idle(6, RO_ALL & ~10'h010);
        idle(6, RO_ALL);

        // Reset with flits buffered, then fresh traffic
        for (int k = 0; k < 3; k++) begin
            dv = '0;
            dv[0 +: DW] = mk(1'(k % 2), 4'd2, 4'd2);
            applyStimulus(1'b0, 5'b00001, dv, '0);
        end
        applyStimulus(1'b1, '0, '0, '0);
        idle(3, RO_ALL);
        dv = '0;
        dv[2*DW +: DW] = mk(1'b1, 4'd0, 4'd1);
        applyStimulus(1'b0, 5'b00100, dv, RO_ALL);
        idle(4, RO_ALL);

        // Random traffic with random backpressure and occasional reset
        for (int c = 0; c < 2000; c++) begin
            dv = '0;
            sv = '0;
            for (int i = 0; i < 5; i++) begin
                sv[i] = ($urandom_range(0, 1) == 1);
                dv[i*DW +: DW] = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 2)),
                                    4'($urandom_range(0, 2)));
            end
            for (int b = 0; b < 10; b++) rv[b] = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus(rst, sv, dv, rv);
        end
        idle(10, RO_ALL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
